// File: rtl/rvfi_pkg.sv
// rvfi_pkg: RVFI commit packet type shared by the stimulus generator and its
// consumers. XLEN/VLEN are both 64; fields not driven by a producer are zero.
package rvfi_pkg;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [31:0]       insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [1:0]        mode;
        logic [1:0]        ixl;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [7:0]        mem_rmask;
        logic [7:0]        mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;

endpackage

// File: rtl/rvfi_stim_gen_if.sv
// rvfi_stim_gen_if: control and commit-packet bundle of the RVFI stimulus
// generator.
//   start_i      begin a run (honoured only when the generator is idle/done)
//   num_instr_i  number of body instructions, captured with start_i
//   exit_code_i  31-bit exit code, captured with start_i
//   pause_i      stall body emission
//   rvfi_o       registered commit packets, one per commit port
//   busy_o       run in progress (body or termination store)
//   done_o       run finished
//   count_o      body instructions emitted so far
// Modports: master = controller/consumer side, slave = generator side.
interface rvfi_stim_gen_if #(
    parameter int unsigned NR_COMMIT_PORTS = 2
);
    logic                                        start_i;
    logic [31:0]                                 num_instr_i;
    logic [30:0]                                 exit_code_i;
    logic                                        pause_i;
    rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_o;
    logic                                        busy_o;
    logic                                        done_o;
    logic [31:0]                                 count_o;

    modport master (
        output start_i, num_instr_i, exit_code_i, pause_i,
        input  rvfi_o, busy_o, done_o, count_o
    );

    modport slave (
        input  start_i, num_instr_i, exit_code_i, pause_i,
        output rvfi_o, busy_o, done_o, count_o
    );
endinterface

// File: rtl/rvfi_stim_gen.sv
// rvfi_stim_gen: synthetic RVFI commit-stream generator.
// Emits num_instr body instructions (ADDI rd, x0, imm) starting at BOOT_ADDR,
// up to NR_COMMIT_PORTS per cycle, followed by one SD to TOHOST_ADDR carrying
// {exit_code, 1'b1}.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   ctrl    rvfi_stim_gen_if.slave (start/num_instr/exit_code/pause in,
//           rvfi/busy/done/count out)
// Build option: define RVFI_STIM_TRAP_EN to mark every body packet whose
// sequence index s satisfies s mod TRAP_PERIOD == TRAP_PERIOD-1 as a trap
// (valid=0, trap=1). Without it trap is always 0 and TRAP_PERIOD is unused.
module rvfi_stim_gen #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter logic [63:0] BOOT_ADDR       = 64'h8000_0000,
    parameter logic [63:0] TOHOST_ADDR     = 64'h8000_1000,
    parameter int unsigned TRAP_PERIOD     = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rvfi_stim_gen_if.slave ctrl
);
    import rvfi_pkg::*;

    typedef rvfi_instr_t [NR_COMMIT_PORTS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

    // The state register names what is visible on rvfi_o during the current
    // cycle, so the first packets are registered on the very edge that
    // samples start_i. In RUN with count_q == num_q every body packet is out
    // and the next edge loads the termination store.
    state_t      state_q;
    logic [31:0] num_q;
    logic [30:0] exit_q;
    logic [31:0] count_q;
    frame_t      rvfi_q;

    function automatic rvfi_instr_t body_pkt(input logic [31:0] s);
        rvfi_instr_t p;
        p          = '0;
        p.valid    = 1'b1;
        p.order    = {32'b0, s};
        p.pc_rdata = BOOT_ADDR + {30'b0, s, 2'b00};
        p.rd_addr  = 5'((s % 32'd31) + 32'd1);
        p.insn     = {s[11:0], 5'd0, 3'b000, p.rd_addr, 7'b0010011};
        p.rd_wdata = {{52{s[11]}}, s[11:0]};
        p.mode     = 2'b11;
`ifdef RVFI_STIM_TRAP_EN
        if ((s % TRAP_PERIOD) == (TRAP_PERIOD - 1)) begin
            p.valid = 1'b0;
            p.trap  = 1'b1;
        end
`endif
        return p;
    endfunction

    function automatic frame_t term_frame(input logic [31:0] n, input logic [30:0] code);
        frame_t f;
        f                = '0;
        f[0].valid       = 1'b1;
        f[0].insn        = {7'b0, 5'd1, 5'd2, 3'b011, 5'b0, 7'b0100011};
        f[0].pc_rdata    = BOOT_ADDR + {30'b0, n, 2'b00};
        f[0].mem_addr    = TOHOST_ADDR;
        f[0].mem_wmask   = 8'hFF;
        f[0].mem_wdata   = {33'b0, code, 1'b1};
        return f;
    endfunction

    // Next body batch: from index 0 when starting, otherwise continuing after
    // the packets already emitted.
    logic [31:0] base;
    logic [31:0] rem;
    logic [31:0] batch_k;
    frame_t      batch;

    always_comb begin
        if (state_q == RUN) begin
            base = count_q;
            rem  = num_q - count_q;
        end else begin
            base = '0;
            rem  = ctrl.num_instr_i;
        end
        batch_k = (rem >= NR_COMMIT_PORTS) ? NR_COMMIT_PORTS : rem;
        batch   = '0;
        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (p < batch_k) begin
                batch[p] = body_pkt(base + p);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            num_q   <= '0;
            exit_q  <= '0;
            count_q <= '0;
            rvfi_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rvfi_q <= '0;
                    if (ctrl.start_i) begin
                        num_q  <= ctrl.num_instr_i;
                        exit_q <= ctrl.exit_code_i;
                        if (ctrl.num_instr_i == '0) begin
                            state_q <= TERM;
                            count_q <= '0;
                            rvfi_q  <= term_frame('0, ctrl.exit_code_i);
                        end else begin
                            state_q <= RUN;
                            if (ctrl.pause_i) begin
                                count_q <= '0;
                            end else begin
                                count_q <= batch_k;
                                rvfi_q  <= batch;
                            end
                        end
                    end
                end
                RUN: begin
                    if (count_q == num_q) begin
                        state_q <= TERM;
                        rvfi_q  <= term_frame(num_q, exit_q);
                    end else if (ctrl.pause_i) begin
                        rvfi_q <= '0;
                    end else begin
                        rvfi_q  <= batch;
                        count_q <= count_q + batch_k;
                    end
                end
                TERM: begin
                    state_q <= DONE;
                    rvfi_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    rvfi_q  <= '0;
                end
            endcase
        end
    end

    assign ctrl.rvfi_o  = rvfi_q;
    assign ctrl.busy_o  = (state_q == RUN) || (state_q == TERM);
    assign ctrl.done_o  = (state_q == DONE);
    assign ctrl.count_o = count_q;

endmodule

// File: doc/rvfi_stim_gen.md
RVFI_STIM_GEN -- requirements
Module: rvfi_stim_gen

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of RVFI commit ports driven.
REQ-002 SHALL have parameter BOOT_ADDR, default 64'h8000_0000, PC of the first generated instruction.
REQ-003 SHALL have parameter TOHOST_ADDR, default 64'h8000_1000, store address of the termination write.
REQ-004 SHALL have parameter TRAP_PERIOD, default 8, trap injection period (used only per REQ-024).
REQ-005 SHALL have ports: clk_i  input  1  clock.
REQ-006 SHALL have: rst_ni  input  1  reset. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have: start_i  input  1  begin a run (sampled in IDLE/DONE only).
REQ-008 SHALL have: num_instr_i  input  32  body instructions to emit; sampled with start_i.
REQ-009 SHALL have: exit_code_i  input  31  exit code; sampled with start_i.
REQ-010 SHALL have: pause_i  input  1  stall body emission.
REQ-011 SHALL have: rvfi_o  output  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  generated commit packets, registered.
REQ-012 SHALL have: busy_o  output  1  high in RUN/TERM; done_o  output  1  high in DONE; count_o  output  32  body instructions emitted so far.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> TERM -> DONE; DONE -> RUN on start_i; start_i ignored in RUN/TERM.
REQ-014 On start_i in IDLE/DONE: latch num_instr_i, exit_code_i; count_o <= 0; next state RUN, or TERM if num_instr_i == 0.
REQ-015 First valid packet SHALL appear on rvfi_o the cycle after start_i is sampled.
REQ-016 In RUN with pause_i low: emit k = min(NR_COMMIT_PORTS, remaining) packets on ports 0..k-1, ports k.. all-zero; count_o += k; go TERM when remaining reaches 0.
REQ-017 In RUN with pause_i high: all ports all-zero, count_o held, state held.
REQ-018 Body packet for sequence index s: valid=1, order=s, pc_rdata = BOOT_ADDR + 4*s (VLEN-truncated), insn = ADDI rd, x0, s[11:0] (opcode 0010011, funct3 000, rs1 0), rd_addr = (s mod 31)+1, rd_wdata = sign-extended s[11:0], mode = 2'b11, mem_* = 0.
REQ-019 Sequence indices SHALL be assigned in increasing order from port 0 upward within a cycle.
REQ-020 TERM SHALL last exactly one cycle: port 0 valid=1, insn = SD x1, 0(x2) (opcode 0100011, funct3 011), pc_rdata = BOOT_ADDR + 4*N, mem_addr = TOHOST_ADDR, mem_wmask = 8'hFF, mem_wdata = {exit_code, 1'b1} zero-extended to XLEN; other ports zero; pause_i ignored.
REQ-021 All rvfi fields not listed SHALL be zero; in IDLE/DONE all ports all-zero.
REQ-022 count_o SHALL hold its final value in DONE until next start.

Reset
REQ-023 rst_ni low (any time, including mid-run) SHALL asynchronously force IDLE, rvfi_o all-zero, busy_o=0, done_o=0, count_o=0, latched inputs 0.

Configuration
REQ-024 Macro RVFI_STIM_TRAP_EN defined: body packet with s mod TRAP_PERIOD == TRAP_PERIOD-1 emitted with valid=0, trap=1, other fields per REQ-018, still counted. Undefined: trap always 0, TRAP_PERIOD unused.

Verification
REQ-025 start_i with num_instr_i=5, exit_code=0, NR=2 -> cycles 1-3 emit 2,2,1 valid packets (pc 0x8000_0000..0x8000_0010), cycle 4 SD with mem_wdata=1, then done_o=1, count_o=5.
REQ-026 num_instr_i=0, exit_code=0x15 -> next cycle TERM packet, mem_wdata=0x2B, mem_addr=0x8000_1000.
REQ-027 pause_i high 3 cycles mid-run -> 3 all-zero cycles, count_o frozen, sequence resumes without gap.
REQ-028 rst_ni low during RUN after 3 instrs -> outputs zero immediately; after release, IDLE; start_i restarts at pc 0x8000_0000.
REQ-029 With RVFI_STIM_TRAP_EN, num_instr_i=16 -> indices 7 and 15 have valid=0, trap=1; without macro all 16 valid.
REQ-030 Connect to the RVFI trace consumer with matching TOHOST_ADDR -> simulation terminates reporting exit value {exit_code,1}.
